// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one pipelined 32x32 multiplier among N_REQ requesters.
// Credit-limited issue keeps the in-order result FIFO from ever overflowing.
module mult_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned MULT_LAT   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned IDW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 CLK,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    output logic [31:0]          mult_a,
    output logic [31:0]          mult_b,
    input  logic [63:0]          mult_c,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_c,
    output logic [IDW-1:0]       rsp_id
);

    localparam int unsigned PW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [IDW-1:0] r_ptr;
    logic [CW-1:0]  r_in_flight;
    logic [CW-1:0]  r_fifo_cnt;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [63:0]    r_mem_c  [FIFO_DEPTH];
    logic [IDW-1:0] r_mem_id [FIFO_DEPTH];

    // r_op_* tracks the operands sitting in mult_a/mult_b; r_tag_* follows the multiplier stages.
    logic                r_op_v;
    logic [IDW-1:0]      r_op_id;
    logic [MULT_LAT-1:0] r_tag_v;
    logic [IDW-1:0]      r_tag_id [MULT_LAT];

    logic           w_found;
    logic           w_credit;
    logic           w_issue;
    logic           w_push;
    logic           w_pop;
    logic [IDW-1:0] w_cand;
    logic [IDW-1:0] w_gnt_id;

    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_cand   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = IDW'((32'(r_ptr) + 32'(k)) % N_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_gnt_id = w_cand;
            end
        end
    end

    // Registered counts only: a pop this cycle frees its credit next cycle.
    assign w_credit  = ({1'b0, r_in_flight} + {1'b0, r_fifo_cnt}) < DEPTH_W;
    assign w_issue   = w_found && w_credit && !rst;
    assign w_push    = r_tag_v[MULT_LAT-1];
    assign rsp_valid = (r_fifo_cnt != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_c     = r_mem_c[r_rd_ptr];
    assign rsp_id    = r_mem_id[r_rd_ptr];

    always_comb begin
        req_ready = '0;
        if (w_issue) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_ptr  <= '0;
            mult_a <= '0;
            mult_b <= '0;
        end else if (w_issue) begin
            r_ptr  <= IDW'((32'(w_gnt_id) + 32'd1) % N_REQ);
            mult_a <= req_a[32*w_gnt_id +: 32];
            mult_b <= req_b[32*w_gnt_id +: 32];
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_op_v  <= 1'b0;
            r_op_id <= '0;
            r_tag_v <= '0;
            for (int s = 0; s < MULT_LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else begin
            r_op_v      <= w_issue;
            r_op_id     <= w_gnt_id;
            r_tag_v[0]  <= r_op_v;
            r_tag_id[0] <= r_op_id;
            for (int s = 1; s < MULT_LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
                r_mem_c[e]  <= '0;
                r_mem_id[e] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem_c[r_wr_ptr]  <= mult_c;
                r_mem_id[r_wr_ptr] <= r_tag_id[MULT_LAT-1];
                r_wr_ptr           <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_fifo_cnt  <= '0;
            r_in_flight <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
                2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
            case ({w_issue, w_push})
                2'b10:   r_in_flight <= r_in_flight + CW'(1);
                2'b01:   r_in_flight <= r_in_flight - CW'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (rst)
        !(w_push && r_fifo_cnt == CW'(FIFO_DEPTH)));

    a_one_grant: assert property (@(posedge CLK) $onehot0(req_ready));

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a 2-stage multiplier model and a response scoreboard.
module tb_mult_arbiter;

    localparam int N = 4;

    logic            CLK = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [31:0]     mult_a;
    logic [31:0]     mult_b;
    logic [63:0]     mult_c;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [63:0]     rsp_c;
    logic [1:0]      rsp_id;

    logic [63:0] r_mp0;
    logic [63:0] r_mp1;

    int          n_chk;
    int          n_err;
    int          n_iss;
    int          n_rsp;
    int          m_ptr;
    logic [63:0] q_c[$];
    int          q_id[$];

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        r_mp0 <= {32'd0, mult_a} * {32'd0, mult_b};
        r_mp1 <= r_mp0;
    end
    assign mult_c = r_mp1;

    mult_arbiter #(
        .N_REQ      (4),
        .MULT_LAT   (2),
        .FIFO_DEPTH (4)
    ) u_dut (
        .CLK       (CLK),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mult_a    (mult_a),
        .mult_b    (mult_b),
        .mult_c    (mult_c),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_c     (rsp_c),
        .rsp_id    (rsp_id)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        rst   = 1'b0;
        n_iss = 0;
        n_rsp = 0;
        m_ptr = 0;
        q_c.delete();
        q_id.delete();
    endtask

    // Called one unit after a rising edge with inputs already set; returns one unit after the next.
    task automatic eval_cycle();
        int         g;
        logic [3:0] exp_oh;
        #1;
        g      = model_grant(req_valid, m_ptr);
        exp_oh = (g >= 0) ? 4'(1 << g) : 4'b0000;
        if (req_ready != '0) begin
            check("grant", 64'(req_ready), 64'(exp_oh));
            if (g >= 0) begin
                q_c.push_back({32'd0, req_a[32*g +: 32]} * {32'd0, req_b[32*g +: 32]});
                q_id.push_back(g);
                m_ptr = (g + 1) % N;
            end
            n_iss++;
        end
        if (rsp_valid && rsp_ready) begin
            if (q_c.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                check("rsp_c", rsp_c, q_c.pop_front());
                check("rsp_id", 64'(rsp_id), 64'(q_id.pop_front()));
            end
            n_rsp++;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_chk     = 0;
        n_err     = 0;
        n_iss     = 0;
        n_rsp     = 0;
        m_ptr     = 0;
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        req_a     = '0;
        req_b     = '0;

        // Reset state, with every requester asking.
        repeat (2) @(posedge CLK);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_mult_a", 64'(mult_a), 64'd0);
        check("rst_mult_b", 64'(mult_b), 64'd0);
        check("rst_rsp_c", rsp_c, 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);

        rst       = 1'b0;
        req_valid = 4'b1110;
        #1;
        check("first_grant_lowest", 64'(req_ready), 64'(4'b0010));
        req_valid = '0;

        // Single request: 7 * 6, result three edges after acceptance.
        set_op(0, 32'd7, 32'd6);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        #1;
        check("single_ready", 64'(req_ready), 64'(4'b0001));
        @(posedge CLK);
        #1;
        req_valid = '0;
        check("single_mult_a", 64'(mult_a), 64'd7);
        check("single_mult_b", 64'(mult_b), 64'd6);
        check("single_rsp_valid_0", 64'(rsp_valid), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK);
            #1;
            check("single_rsp_valid_lat", 64'(rsp_valid), (k == 3) ? 64'd1 : 64'd0);
        end
        check("single_rsp_c", rsp_c, 64'd42);
        check("single_rsp_id", 64'(rsp_id), 64'd0);
        @(posedge CLK);
        #1;
        check("single_popped", 64'(rsp_valid), 64'd0);

        // Fairness: all valid, grants rotate 0,1,2,3,0,...
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'(10 + i), 32'd3);
        rsp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            req_valid = (n_iss < 8) ? 4'b1111 : 4'b0000;
            eval_cycle();
        end
        check("fair_issues", 64'(n_iss), 64'd8);
        check("fair_rsps", 64'(n_rsp), 64'd8);

        // Backpressure: four credits, then a single pop frees one issue.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'(100 + i), 32'(1000 + 7 * i));
        req_valid = 4'b1111;
        repeat (10) eval_cycle();
        check("bp_issues", 64'(n_iss), 64'd4);
        #1;
        check("bp_stalled", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        #1;
        check("bp_no_grant_on_pop", 64'(req_ready), 64'd0);
        check("bp_head_id", 64'(rsp_id), 64'd0);
        eval_cycle();
        rsp_ready = 1'b0;
        #1;
        check("bp_one_grant", 64'(req_ready), 64'(4'b0001));
        repeat (6) eval_cycle();
        check("bp_issues_after_pop", 64'(n_iss), 64'd5);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) eval_cycle();
        check("bp_drain", 64'(n_rsp), 64'd5);

        // Full-width operands.
        do_reset();
        set_op(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rsp_ready = 1'b1;
        req_valid = 4'b1000;
        #1;
        check("wide_grant", 64'(req_ready), 64'(4'b1000));
        @(posedge CLK);
        #1;
        req_valid = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("wide_rsp_valid", 64'(rsp_valid), 64'd1);
        check("wide_rsp_c", rsp_c, 64'hFFFF_FFFE_0000_0001);
        check("wide_rsp_id", 64'(rsp_id), 64'd3);
        @(posedge CLK);
        #1;

        // Reset pulse while three results are in flight.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'(20 + i), 32'(2 + i));
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        repeat (3) eval_cycle();
        check("mr_issues", 64'(n_iss), 64'd3);
        rst       = 1'b1;
        req_valid = '0;
        @(posedge CLK);
        #1;
        rst = 1'b0;
        q_c.delete();
        q_id.delete();
        m_ptr = 0;
        repeat (6) begin
            check("mr_rsp_valid", 64'(rsp_valid), 64'd0);
            @(posedge CLK);
            #1;
        end
        req_valid = 4'b1111;
        #1;
        check("mr_next_grant", 64'(req_ready), 64'(4'b0001));
        req_valid = '0;

        // Push and pop on the same edge with two results buffered.
        do_reset();
        for (int i = 0; i < N; i++) set_op(i, 32'(5 + i), 32'(7 + 2 * i));
        req_valid = 4'b0011;
        repeat (2) eval_cycle();
        req_valid = '0;
        repeat (4) eval_cycle();
        req_valid = 4'b0100;
        eval_cycle();
        req_valid = '0;
        repeat (2) eval_cycle();
        rsp_ready = 1'b1;
        eval_cycle();
        rsp_ready = 1'b0;
        check("pp_issues", 64'(n_iss), 64'd3);
        check("pp_pops", 64'(n_rsp), 64'd1);
        req_valid = 4'b1111;
        repeat (8) eval_cycle();
        check("pp_credit", 64'(n_iss), 64'd5);
        #1;
        check("pp_stalled", 64'(req_ready), 64'd0);
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (12) eval_cycle();
        check("pp_drain", 64'(n_rsp), 64'd5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one 32x32 multiplier.
REQ-002 Parameter MULT_LAT, default 2, fixed cycles from operands driven on mult_a/mult_b to the matching product on mult_c.
REQ-003 Parameter FIFO_DEPTH, default 4, result buffer entries; power of two, at least 2.
REQ-004 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  N_REQ  per-requester operand valid.
REQ-007 req_ready  out  N_REQ  per-requester grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 req_a, req_b  in  N_REQ*32 each  packed operands; requester i uses bits [32*i+31:32*i].
REQ-009 mult_a, mult_b  out  32 each  registered operands to the shared multiplier.
REQ-010 mult_c  in  64  product from the shared multiplier.
REQ-011 rsp_valid  out  1  result FIFO head valid.
REQ-012 rsp_ready  in  1  consumer accepts head.
REQ-013 rsp_c  out  64  unsigned product at FIFO head.
REQ-014 rsp_id  out  $clog2(N_REQ)  index of the requester that issued the head result.

Function
REQ-015 At most one bit of req_ready is high in any cycle.
REQ-016 req_ready is combinational from req_valid, the round-robin pointer and the credit state; it is never high for a requester whose req_valid is low.
REQ-017 Issue is allowed only when in_flight + fifo_count < FIFO_DEPTH, using registered counts; a FIFO pop in the same cycle does not enable an issue that cycle.
REQ-018 Round-robin: search starts at index ptr and wraps through N_REQ-1 to 0; the first valid requester is granted; on a transfer ptr becomes (granted index + 1) mod N_REQ; with no transfer ptr holds.
REQ-019 On a transfer at edge e, mult_a/mult_b load the granted operands; with no transfer, mult_a/mult_b hold their previous values.
REQ-020 A MULT_LAT-stage tag pipeline carries {valid, id} alongside each issue; stage MULT_LAT valid means mult_c in that cycle is the matching product.
REQ-021 When the tag pipeline output is valid, {mult_c, id} is written into the FIFO at the next edge; with an empty FIFO, rsp_valid rises MULT_LAT+1 edges after the transfer edge.
REQ-022 A write can never find the FIFO full, because of REQ-017; an assertion flags any such overflow.
REQ-023 FIFO pop occurs when rsp_valid and rsp_ready are both high; a simultaneous push and pop leaves fifo_count unchanged; read and write pointers wrap mod FIFO_DEPTH.
REQ-024 in_flight increments on an issue, decrements on a FIFO write, and is unchanged when both happen in the same cycle.
REQ-025 Results leave in issue order; rsp_c/rsp_id hold stable while rsp_valid is high and rsp_ready is low.
REQ-026 Throughput: one issue per cycle while credits are available and any req_valid is high.

Reset
REQ-027 While rst is high: req_ready=0, rsp_valid=0, mult_a=mult_b=0, rsp_c=0, rsp_id=0, ptr=0, counts=0, tag pipeline cleared.
REQ-028 Reset asserted mid-operation discards all in-flight and buffered results; mult_c is ignored until new issues reach the end of the tag pipeline.
REQ-029 The first grant after reset release goes to the lowest valid index.

Verification (N_REQ=4, MULT_LAT=2, FIFO_DEPTH=4)
REQ-030 Single request: req_valid=0001, a=7, b=6, rsp_ready=1 -> req_ready[0] high; rsp_valid rises 3 edges after acceptance with rsp_c=42, rsp_id=0.
REQ-031 Fairness: all four requesters valid continuously -> grant order 0,1,2,3,0,...; each returned rsp_id matches the issuing order.
REQ-032 Backpressure: rsp_ready=0 with all requesters valid -> exactly 4 issues, then req_ready=0; one pop frees exactly one issue, starting the cycle after the pop.
REQ-033 Width: a=b=32'hFFFF_FFFF -> rsp_c=64'hFFFF_FFFE_0000_0001.
REQ-034 Mid-operation reset: 3 issued, rst pulsed for 1 cycle before any write -> rsp_valid stays 0 and the next grant goes to index 0.
REQ-035 Simultaneous push/pop at fifo_count=2 -> count stays 2; ordering and ids are preserved.
